// File: rtl/btc_enc_ctrl_pkg.sv
//------------------------------------------------------------------------------
// btc_enc_ctrl_pkg : shared types and length helpers for the BTC encoder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package btc_enc_ctrl_pkg;

  localparam int cLOG2_ROW_MAX = 5;  // up to 32 rows in the code array
  localparam int cLOG2_COL_MAX = 6;  // up to 64 bits in a row
  localparam int cLEN_W        = 7;

  typedef enum logic [1:0] {
    eWOPC = 2'd0,
    eSPC  = 2'd1,
    eHAM  = 2'd2
  } btc_code_t;

  // Component code: n = 2**size code bits
  typedef struct packed {
    btc_code_t  code;
    logic [2:0] size;
  } btc_code_mode_t;

  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
    logic mask;
  } strb_t;

  typedef enum logic [2:0] {
    RESET    = 3'd0,
    WAIT     = 3'd1,
    DO_ROW   = 3'd2,
    WAIT_ROW = 3'd3,
    DO_COL   = 3'd4,
    WAIT_COL = 3'd5,
    DONE     = 3'd6
  } btc_enc_state_t;

  function automatic logic [cLEN_W-1:0] get_code_bits(input btc_code_mode_t m);
    get_code_bits = cLEN_W'(1) << m.size;
  endfunction

  function automatic logic [cLEN_W-1:0] get_data_bits(input btc_code_mode_t m);
    logic [cLEN_W-1:0] n;
    n = get_code_bits(m);
    case (m.code)
      eSPC:    get_data_bits = n - 7'd1;
      eHAM:    get_data_bits = n - {4'd0, m.size} - 7'd1;
      default: get_data_bits = n;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/btc_enc_idx_cnt.sv
//------------------------------------------------------------------------------
// btc_enc_idx_cnt : nested inner/outer index counter with registered zero/done
// flags; lengths are latched on load. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btc_enc_idx_cnt #(
  parameter int pIN_W  = 6,
  parameter int pOUT_W = 5
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iclkena,
  input  logic              iload,
  input  logic              iinc,
  input  logic [pIN_W-1:0]  iin_len_m2,
  input  logic              iin_one,
  input  logic [pOUT_W-1:0] iout_len_m2,
  input  logic              iout_one,
  output logic [pIN_W-1:0]  oin_idx,
  output logic [pOUT_W-1:0] oout_idx,
  output logic              oin_zero,
  output logic              oin_done,
  output logic              oout_zero,
  output logic              oout_done
);

  logic [pIN_W-1:0]  r_in_len_m2;
  logic [pOUT_W-1:0] r_out_len_m2;
  logic              r_in_one;
  logic              r_out_one;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      oin_idx      <= '0;
      oout_idx     <= '0;
      oin_zero     <= 1'b1;
      oout_zero    <= 1'b1;
      oin_done     <= 1'b0;
      oout_done    <= 1'b0;
      r_in_len_m2  <= '0;
      r_out_len_m2 <= '0;
      r_in_one     <= 1'b0;
      r_out_one    <= 1'b0;
    end else if (iclkena) begin
      if (iload) begin
        oin_idx      <= '0;
        oout_idx     <= '0;
        oin_zero     <= 1'b1;
        oout_zero    <= 1'b1;
        oin_done     <= iin_one;
        oout_done    <= iout_one;
        r_in_len_m2  <= iin_len_m2;
        r_out_len_m2 <= iout_len_m2;
        r_in_one     <= iin_one;
        r_out_one    <= iout_one;
      end else if (iinc) begin
        // done is armed one step early so no full-length compare sits on the wrap path
        if (oin_done) begin
          oin_idx  <= '0;
          oin_zero <= 1'b1;
          oin_done <= r_in_one;
          if (oout_done) begin
            oout_idx  <= '0;
            oout_zero <= 1'b1;
            oout_done <= r_out_one;
          end else begin
            oout_idx  <= oout_idx + 1'b1;
            oout_zero <= 1'b0;
            oout_done <= (oout_idx == r_out_len_m2);
          end
        end else begin
          oin_idx  <= oin_idx + 1'b1;
          oin_zero <= 1'b0;
          oin_done <= (oin_idx == r_in_len_m2);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/btc_enc_ctrl.sv
//------------------------------------------------------------------------------
// btc_enc_ctrl : row-then-column read sequencer for the BTC product encoder.
// Optional frame counter output under BTC_ENC_FRM_CNT_EN. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module btc_enc_ctrl
  import btc_enc_ctrl_pkg::*;
#(
  parameter int pADDR_W  = 8,
  parameter int pDEC_NUM = 8
) (
  input  logic                        iclk,
  input  logic                        ireset,
  input  logic                        iclkena,
  input  btc_code_mode_t              ixmode,
  input  btc_code_mode_t              iymode,
  input  logic                        irbuf_full,
  output logic                        obuf_rempty,
  input  logic                        iwbuf_empty,
  output logic                        owbuf_full,
  output logic [pADDR_W-1:0]          obuf_addr,
  output logic [$clog2(pDEC_NUM)-1:0] obit_sel,
  output logic                        orow_mode,
  input  logic                        ienc_busy,
  output logic [pDEC_NUM-1:0]         oenc_val,
  output strb_t                       oenc_strb
`ifdef BTC_ENC_FRM_CNT_EN
  ,
  output logic [15:0]                 ofrm_cnt
`endif
);

  localparam int cLOG2_DEC = $clog2(pDEC_NUM);
  localparam int cWORD_W   = cLOG2_COL_MAX - cLOG2_DEC;
  localparam int cROW_W    = pADDR_W - cWORD_W;

  btc_enc_state_t r_state;
  logic [cLEN_W-1:0] r_xk;
  logic [cLEN_W-1:0] r_yk;

  logic [cLEN_W-1:0] w_xn, w_xk, w_yn, w_yk, w_words;
  logic              w_start;

  logic [cLOG2_COL_MAX-1:0] w_row_c;
  logic [cLOG2_ROW_MAX-1:0] w_row_r;
  logic                     w_row_czero, w_row_cdone, w_row_rzero, w_row_rdone;
  logic [cLOG2_ROW_MAX-1:0] w_col_r;
  logic [cWORD_W-1:0]       w_col_w;
  logic                     w_col_rzero, w_col_rdone, w_col_wzero, w_col_wdone;

  assign w_xn    = get_code_bits(ixmode);
  assign w_xk    = get_data_bits(ixmode);
  assign w_yn    = get_code_bits(iymode);
  assign w_yk    = get_data_bits(iymode);
  assign w_words = w_xn >> cLOG2_DEC;
  assign w_start = (r_state == WAIT) && irbuf_full && iwbuf_empty;

  btc_enc_idx_cnt #(
    .pIN_W  (cLOG2_COL_MAX),
    .pOUT_W (cLOG2_ROW_MAX)
  ) u_row_cnt (
    .iclk        (iclk),
    .ireset      (ireset),
    .iclkena     (iclkena),
    .iload       (w_start),
    .iinc        (r_state == DO_ROW),
    .iin_len_m2  (cLOG2_COL_MAX'(w_xn - 7'd2)),
    .iin_one     (w_xn == 7'd1),
    .iout_len_m2 (cLOG2_ROW_MAX'(w_yk - 7'd2)),
    .iout_one    (w_yk == 7'd1),
    .oin_idx     (w_row_c),
    .oout_idx    (w_row_r),
    .oin_zero    (w_row_czero),
    .oin_done    (w_row_cdone),
    .oout_zero   (w_row_rzero),
    .oout_done   (w_row_rdone)
  );

  btc_enc_idx_cnt #(
    .pIN_W  (cLOG2_ROW_MAX),
    .pOUT_W (cWORD_W)
  ) u_col_cnt (
    .iclk        (iclk),
    .ireset      (ireset),
    .iclkena     (iclkena),
    .iload       (w_start),
    .iinc        (r_state == DO_COL),
    .iin_len_m2  (cLOG2_ROW_MAX'(w_yn - 7'd2)),
    .iin_one     (w_yn == 7'd1),
    .iout_len_m2 (cWORD_W'(w_words - 7'd2)),
    .iout_one    (w_words == 7'd1),
    .oin_idx     (w_col_r),
    .oout_idx    (w_col_w),
    .oin_zero    (w_col_rzero),
    .oin_done    (w_col_rdone),
    .oout_zero   (w_col_wzero),
    .oout_done   (w_col_wdone)
  );

  // Idle counters sit at zero, so the row form doubles as the idle address
  assign obuf_addr = (r_state == DO_COL) ? {cROW_W'(w_col_r), w_col_w}
                                         : {cROW_W'(w_row_r), cWORD_W'(w_row_c >> cLOG2_DEC)};
  assign obit_sel  = w_row_c[cLOG2_DEC-1:0];

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_state     <= RESET;
      r_xk        <= '0;
      r_yk        <= '0;
      oenc_val    <= '0;
      oenc_strb   <= '0;
      orow_mode   <= 1'b0;
      obuf_rempty <= 1'b0;
      owbuf_full  <= 1'b0;
    end else if (iclkena) begin
      oenc_val    <= '0;
      oenc_strb   <= '0;
      orow_mode   <= (r_state == DO_ROW);
      obuf_rempty <= 1'b0;
      owbuf_full  <= 1'b0;
      case (r_state)
        RESET: r_state <= WAIT;
        WAIT: begin
          if (w_start) begin
            r_xk    <= w_xk;
            r_yk    <= w_yk;
            r_state <= DO_ROW;
          end
        end
        DO_ROW: begin
          oenc_val       <= pDEC_NUM'(1);
          oenc_strb.sof  <= w_row_czero && w_row_rzero;
          oenc_strb.sop  <= w_row_czero;
          oenc_strb.eop  <= w_row_cdone;
          oenc_strb.eof  <= w_row_cdone && w_row_rdone;
          oenc_strb.mask <= (cLEN_W'(w_row_c) >= r_xk);
          if (w_row_cdone && w_row_rdone) r_state <= WAIT_ROW;
        end
        WAIT_ROW: if (!ienc_busy) r_state <= DO_COL;
        DO_COL: begin
          oenc_val       <= '1;
          oenc_strb.sof  <= w_col_rzero && w_col_wzero;
          oenc_strb.sop  <= w_col_rzero;
          oenc_strb.eop  <= w_col_rdone;
          oenc_strb.eof  <= w_col_rdone && w_col_wdone;
          oenc_strb.mask <= (cLEN_W'(w_col_r) >= r_yk);
          if (w_col_rdone && w_col_wdone) r_state <= WAIT_COL;
        end
        WAIT_COL: begin
          if (!ienc_busy) begin
            obuf_rempty <= 1'b1;
            owbuf_full  <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE:    r_state <= WAIT;
        default: r_state <= RESET;
      endcase
    end
  end

`ifdef BTC_ENC_FRM_CNT_EN
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset)                             ofrm_cnt <= '0;
    else if (iclkena && (r_state == DONE))  ofrm_cnt <= ofrm_cnt + 16'd1;
  end
`endif

endmodule

`default_nettype wire
